// File: rtl/rs232_pkg.sv
// Shared constants and helpers for the RS-232 buffering blocks.
package rs232_pkg;

  localparam int DEFAULT_WORD_LEN = 8;
  localparam int DEFAULT_DEPTH    = 16;

  // Ceiling log2 for tools lacking $clog2; returns 0 for values of 1 or less.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x WORD_LEN storage: one synchronous write port, one asynchronous read port.
module fifo_ram #(
  parameter int WORD_LEN = 8,
  parameter int DEPTH    = 16,
  parameter int AW       = 4
) (
  input  logic                clk,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [WORD_LEN-1:0] wdata,
  input  logic [AW-1:0]       raddr,
  output logic [WORD_LEN-1:0] rdata
);

  logic [WORD_LEN-1:0] mem [DEPTH];

  // NOTE: storage carries no reset; the pointers alone define which words are live.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with occupancy count, threshold flags, sticky error flags,
// synchronous clear and a selectable registered or first-word-fall-through read.
module fifo_sync_flags
  import rs232_pkg::*;
#(
  parameter int WORD_LEN = DEFAULT_WORD_LEN,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter bit FWFT     = 1'b0,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  localparam int AW      = clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic [WORD_LEN-1:0] wr_data,
  input  logic                we,
  input  logic                re,
  output logic [WORD_LEN-1:0] rd_data,
  output logic                rd_valid,
  output logic                full,
  output logic                empty,
  output logic                almost_full,
  output logic                almost_empty,
  output logic [AW:0]         count,
  output logic                overflow,
  output logic                underflow
);

  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [AW:0]         wptr;
  logic [AW:0]         rptr;
  logic                wr_acc;
  logic                rd_acc;
  logic [WORD_LEN-1:0] ram_q;

  // One extra pointer bit distinguishes full from empty when the addresses match.
  assign empty        = (wptr == rptr);
  assign full         = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count        = wptr - rptr;
  assign almost_full  = int'(count) >= AF_LEVEL;
  assign almost_empty = int'(count) <= AE_LEVEL;

  // A full FIFO still takes a write when a read frees a slot on the same edge.
  assign rd_acc = re && !empty && !clr;
  assign wr_acc = we && (!full || rd_acc) && !clr;

  fifo_ram #(
    .WORD_LEN (WORD_LEN),
    .DEPTH    (DEPTH),
    .AW       (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wptr[AW-1:0]),
    .wdata (wr_data),
    .raddr (rptr[AW-1:0]),
    .rdata (ram_q)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr      <= '0;
      rptr      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      wptr      <= '0;
      rptr      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wptr <= wptr + PTR_ONE;
      if (rd_acc) rptr <= rptr + PTR_ONE;
      if (we && !wr_acc) overflow <= 1'b1;
      if (re && empty) underflow <= 1'b1;
    end
  end

  generate
    if (FWFT) begin : g_fwft
      assign rd_data  = ram_q;
      assign rd_valid = !empty;
    end else begin : g_registered
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          rd_data  <= '0;
          rd_valid <= 1'b0;
        end else begin
          rd_valid <= rd_acc;
          if (rd_acc) rd_data <= ram_q;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Directed bench: a registered-read FIFO and a FWFT FIFO, both 16x8, sharing clock and reset.
module tb_fifo_sync_flags;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0, we = 1'b0, re = 1'b0;
  logic [7:0] wr_data = '0;
  logic [7:0] rd_data;
  logic       rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;

  logic       f_clr = 1'b0, f_we = 1'b0, f_re = 1'b0;
  logic [7:0] f_wr_data = '0;
  logic [7:0] f_rd_data;
  logic       f_rd_valid, f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
  logic [4:0] f_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fifo_sync_flags #(.WORD_LEN(8), .DEPTH(16), .FWFT(1'b0)) u_dut (
    .clk(clk), .rst(rst), .clr(clr), .wr_data(wr_data), .we(we), .re(re),
    .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  fifo_sync_flags #(.WORD_LEN(8), .DEPTH(16), .FWFT(1'b1)) u_fwft (
    .clk(clk), .rst(rst), .clr(f_clr), .wr_data(f_wr_data), .we(f_we), .re(f_re),
    .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty),
    .almost_full(f_almost_full), .almost_empty(f_almost_empty), .count(f_count),
    .overflow(f_overflow), .underflow(f_underflow)
  );

  // Inputs change and outputs are sampled 1 ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [7:0] base);
    we = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_data = base + 8'(i);
      tick();
    end
    we = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    total++;
    if ({full, empty, almost_full, almost_empty, overflow, underflow, rd_valid} !== 7'b0101000) begin
      bad++;
      $display("FAIL reset_flags got=%b exp=%b", {full, empty, almost_full, almost_empty, overflow, underflow, rd_valid}, 7'b0101000);
    end
    total++;
    if (count !== 5'd0 || rd_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_count_data got=%0d/%h exp=0/00", count, rd_data);
    end
    total++;
    if ({f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow, f_rd_valid, f_count} !== {7'b0101000, 5'd0}) begin
      bad++;
      $display("FAIL reset_fwft got=%b exp=%b", {f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow, f_rd_valid, f_count}, {7'b0101000, 5'd0});
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_fill_drain();
    we = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_data = 8'h41 + 8'(i);
      tick();
      total++;
      if (count !== 5'(i + 1) || almost_full !== (i + 1 >= 14) || almost_empty !== (i + 1 <= 2) || full !== (i == 15)) begin
        bad++;
        $display("FAIL fill_%0d got count=%0d af=%b ae=%b full=%b exp count=%0d af=%b ae=%b full=%b",
                 i, count, almost_full, almost_empty, full, i + 1, i + 1 >= 14, i + 1 <= 2, i == 15);
      end
    end
    we = 1'b0;
    for (int i = 0; i < 16; i++) begin
      re = 1'b1;
      tick();
      re = 1'b0;
      total++;
      if (rd_valid !== 1'b1 || rd_data !== 8'h41 + 8'(i) || count !== 5'(15 - i)) begin
        bad++;
        $display("FAIL drain_%0d got v=%b d=%h c=%0d exp v=1 d=%h c=%0d", i, rd_valid, rd_data, count, 8'h41 + 8'(i), 15 - i);
      end
      tick();
      total++;
      if (rd_valid !== 1'b0 || rd_data !== 8'h41 + 8'(i)) begin
        bad++;
        $display("FAIL pulse_%0d got v=%b d=%h exp v=0 d=%h", i, rd_valid, rd_data, 8'h41 + 8'(i));
      end
    end
    total++;
    if (empty !== 1'b1 || full !== 1'b0) begin
      bad++;
      $display("FAIL drained_empty got empty=%b full=%b exp 1/0", empty, full);
    end
  endtask

  task automatic test_overflow_clr();
    fill(8'h41);
    we = 1'b1;
    wr_data = 8'hFF;
    tick();
    we = 1'b0;
    total++;
    if (overflow !== 1'b1 || count !== 5'd16 || full !== 1'b1) begin
      bad++;
      $display("FAIL overflow got ovf=%b c=%0d full=%b exp 1/16/1", overflow, count, full);
    end
    for (int i = 0; i < 4; i++) begin
      re = 1'b1;
      tick();
      re = 1'b0;
      total++;
      if (rd_data !== 8'h41 + 8'(i)) begin
        bad++;
        $display("FAIL ovf_order_%0d got=%h exp=%h", i, rd_data, 8'h41 + 8'(i));
      end
    end
    total++;
    if (overflow !== 1'b1 || count !== 5'd12) begin
      bad++;
      $display("FAIL ovf_sticky got ovf=%b c=%0d exp 1/12", overflow, count);
    end
    clr = 1'b1; we = 1'b1; re = 1'b1; wr_data = 8'hEE;
    tick();
    clr = 1'b0; we = 1'b0; re = 1'b0;
    total++;
    if (count !== 5'd0 || overflow !== 1'b0 || empty !== 1'b1 || rd_valid !== 1'b0 || rd_data !== 8'h44) begin
      bad++;
      $display("FAIL clr got c=%0d ovf=%b e=%b v=%b d=%h exp 0/0/1/0/44", count, overflow, empty, rd_valid, rd_data);
    end
  endtask

  task automatic test_underflow();
    re = 1'b1;
    tick();
    re = 1'b0;
    total++;
    if (underflow !== 1'b1 || rd_valid !== 1'b0 || count !== 5'd0) begin
      bad++;
      $display("FAIL underflow got unf=%b v=%b c=%0d exp 1/0/0", underflow, rd_valid, count);
    end
    we = 1'b1; re = 1'b1; wr_data = 8'h33;
    tick();
    we = 1'b0; re = 1'b0;
    total++;
    if (count !== 5'd1 || rd_valid !== 1'b0 || empty !== 1'b0) begin
      bad++;
      $display("FAIL wr_re_empty got c=%0d v=%b e=%b exp 1/0/0", count, rd_valid, empty);
    end
    re = 1'b1;
    tick();
    re = 1'b0;
    total++;
    if (rd_data !== 8'h33 || rd_valid !== 1'b1 || count !== 5'd0) begin
      bad++;
      $display("FAIL read_33 got d=%h v=%b c=%0d exp 33/1/0", rd_data, rd_valid, count);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    total++;
    if (underflow !== 1'b0) begin
      bad++;
      $display("FAIL unf_clr got=%b exp=0", underflow);
    end
  endtask

  task automatic test_full_rw();
    fill(8'h10);
    we = 1'b1; re = 1'b1; wr_data = 8'hAA;
    tick();
    we = 1'b0; re = 1'b0;
    total++;
    if (rd_data !== 8'h10 || rd_valid !== 1'b1 || count !== 5'd16 || full !== 1'b1 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL full_rw got d=%h v=%b c=%0d full=%b ovf=%b exp 10/1/16/1/0", rd_data, rd_valid, count, full, overflow);
    end
    re = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      total++;
      if (rd_data !== ((i < 15) ? 8'h11 + 8'(i) : 8'hAA)) begin
        bad++;
        $display("FAIL full_rw_drain_%0d got=%h exp=%h", i, rd_data, (i < 15) ? 8'h11 + 8'(i) : 8'hAA);
      end
    end
    re = 1'b0;
    total++;
    if (empty !== 1'b1 || underflow !== 1'b0) begin
      bad++;
      $display("FAIL full_rw_end got e=%b unf=%b exp 1/0", empty, underflow);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 40; i++) begin
      we = 1'b1;
      wr_data = 8'(i);
      tick();
      we = 1'b0;
      total++;
      if (count !== 5'd1) begin
        bad++;
        $display("FAIL wrap_cnt1_%0d got=%0d exp=1", i, count);
      end
      re = 1'b1;
      tick();
      re = 1'b0;
      total++;
      if (rd_data !== 8'(i) || count !== 5'd0) begin
        bad++;
        $display("FAIL wrap_%0d got d=%h c=%0d exp d=%h c=0", i, rd_data, count, 8'(i));
      end
    end
    total++;
    if ({overflow, underflow, full} !== 3'b000) begin
      bad++;
      $display("FAIL wrap_flags got=%b exp=000", {overflow, underflow, full});
    end
  endtask

  task automatic test_fwft_reset();
    f_we = 1'b1;
    f_wr_data = 8'h5A;
    tick();
    f_we = 1'b0;
    total++;
    if (f_rd_data !== 8'h5A || f_rd_valid !== 1'b1 || f_count !== 5'd1) begin
      bad++;
      $display("FAIL fwft_show got d=%h v=%b c=%0d exp 5A/1/1", f_rd_data, f_rd_valid, f_count);
    end
    f_re = 1'b1;
    tick();
    f_re = 1'b0;
    total++;
    if (f_empty !== 1'b1 || f_rd_valid !== 1'b0 || f_underflow !== 1'b0) begin
      bad++;
      $display("FAIL fwft_pop got e=%b v=%b unf=%b exp 1/0/0", f_empty, f_rd_valid, f_underflow);
    end
    f_we = 1'b1;
    for (int i = 0; i < 3; i++) begin
      f_wr_data = 8'h60 + 8'(i);
      tick();
    end
    total++;
    if (f_count !== 5'd3 || f_rd_data !== 8'h60 || f_rd_valid !== 1'b1) begin
      bad++;
      $display("FAIL fwft_burst got c=%0d d=%h v=%b exp 3/60/1", f_count, f_rd_data, f_rd_valid);
    end
    f_wr_data = 8'h63;
    #2;
    rst = 1'b0;
    #1;
    total++;
    if (f_count !== 5'd0 || f_empty !== 1'b1 || f_full !== 1'b0 || f_rd_valid !== 1'b0 || f_almost_empty !== 1'b1 || f_almost_full !== 1'b0) begin
      bad++;
      $display("FAIL fwft_async_rst got c=%0d e=%b f=%b v=%b ae=%b af=%b exp 0/1/0/0/1/0",
               f_count, f_empty, f_full, f_rd_valid, f_almost_empty, f_almost_full);
    end
    total++;
    if (rd_data !== 8'h00 || rd_valid !== 1'b0 || count !== 5'd0 || empty !== 1'b1) begin
      bad++;
      $display("FAIL reg_async_rst got d=%h v=%b c=%0d e=%b exp 00/0/0/1", rd_data, rd_valid, count, empty);
    end
    f_we = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow_clr();
    test_underflow();
    test_full_rw();
    test_wrap();
    test_fwft_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
